// File: rtl/sample_tx_pkg.sv
// sample_tx_pkg
// Shared definitions for the sample stream transmitter:
//   - tx_state_e   : transmitter FSM states (IDLE, PLAY)
//   - default DATA_WIDTH / DEPTH / PERIOD_WIDTH values
//   - sample_tx_addr_w() : address width for a given memory depth
// Optional feature macro used by the slice: SAMPLE_TX_LOOP_EN (see top).
package sample_tx_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } tx_state_e;

  localparam int SAMPLE_TX_DATA_WIDTH   = 16;
  localparam int SAMPLE_TX_DEPTH        = 256;
  localparam int SAMPLE_TX_PERIOD_WIDTH = 16;

  // Address width needed to index 'depth' words; never narrower than one bit.
  function automatic int sample_tx_addr_w(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/sample_tx_mem.sv
// sample_tx_mem
// Simple dual-port sample RAM: one write port, one read port with a
// registered output, coded so that it maps onto block RAM.
// Ports:
//   clk      in  clock
//   rst      in  synchronous active-high reset (read data register only)
//   wr_en    in  write strobe
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_en    in  read strobe; rd_data updates only on a read
//   rd_addr  in  read address
//   rd_data  out registered read data (holds between reads, 0 after reset)
module sample_tx_mem
  import sample_tx_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_TX_DATA_WIDTH,
  parameter int DEPTH      = SAMPLE_TX_DEPTH,
  parameter int ADDR_W     = sample_tx_addr_w(SAMPLE_TX_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its value when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= {DATA_WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sample_stream_tx.sv
// sample_stream_tx
// Stimulus transmitter: host logic loads a sample record into an internal
// memory; on start the record is played out as a paced valid-only stream,
// one sample every 'period' cycles (period 0 behaves as 1).
// Optional feature macro: SAMPLE_TX_LOOP_EN adds input loop_en; when latched
// high on start, playback wraps to sample 0 after each pass and only abort
// or rst ends it.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   load_valid/load_sample    write a sample at the load pointer
//   load_ready                high in IDLE while memory not full
//   clear                     IDLE only: empty the record (memory untouched)
//   start/num_samples/period  begin playback (IDLE only)
//   abort                     stop playback / cancel a simultaneous start
//   loop_en                   (SAMPLE_TX_LOOP_EN only) repeat passes
//   busy                      high while playing
//   done                      pulse with the last sample of a pass
//   out_valid/out_sample      paced sample stream
//   loaded_count              number of samples loaded
module sample_stream_tx
  import sample_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = SAMPLE_TX_DATA_WIDTH,
  parameter int DEPTH        = SAMPLE_TX_DEPTH,
  parameter int PERIOD_WIDTH = SAMPLE_TX_PERIOD_WIDTH,
  localparam int ADDR_W      = sample_tx_addr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef SAMPLE_TX_LOOP_EN
  input  logic                    loop_en,
`endif
  input  logic                    load_valid,
  input  logic [DATA_WIDTH-1:0]   load_sample,
  output logic                    load_ready,
  input  logic                    clear,
  input  logic                    start,
  input  logic [ADDR_W:0]         num_samples,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_sample,
  output logic [ADDR_W:0]         loaded_count
);

  localparam logic [ADDR_W:0]         CNT_ZERO = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W:0]         CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]         DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [PERIOD_WIDTH-1:0] P_ZERO   = PERIOD_WIDTH'(0);
  localparam logic [PERIOD_WIDTH-1:0] P_ONE    = PERIOD_WIDTH'(1);

  tx_state_e                 state_q, state_d;
  logic [ADDR_W:0]           loaded_count_q, loaded_count_d;
  logic [ADDR_W:0]           n_q, n_d;
  logic [PERIOD_WIDTH-1:0]   p_q, p_d;
  logic [PERIOD_WIDTH-1:0]   pace_q, pace_d;
  logic [ADDR_W:0]           rd_ptr_q, rd_ptr_d;
  logic                      loop_q, loop_d;
  logic                      load_ready_q, load_ready_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      out_valid_q, out_valid_d;

  logic [ADDR_W:0]           n_start_s;
  logic [PERIOD_WIDTH-1:0]   p_start_s;
  logic                      last_rd_s;
  logic                      mem_we_s;
  logic                      rd_fire_s;
  logic [DATA_WIDTH-1:0]     rd_data_s;

  // Values latched on an accepted start: N uses the pre-write count.
  assign n_start_s = (num_samples < loaded_count_q) ? num_samples : loaded_count_q;
  assign p_start_s = (period == P_ZERO) ? P_ONE : period;
  assign last_rd_s = ((rd_ptr_q + CNT_ONE) == n_q);

  // Next-state logic for loading, start acceptance, pacing and the FSM.
  always_comb begin
    state_d        = state_q;
    loaded_count_d = loaded_count_q;
    n_d            = n_q;
    p_d            = p_q;
    pace_d         = pace_q;
    rd_ptr_d       = rd_ptr_q;
    loop_d         = loop_q;
    out_valid_d    = 1'b0;
    done_d         = 1'b0;
    mem_we_s       = 1'b0;
    rd_fire_s      = 1'b0;

    case (state_q)
      IDLE: begin
        // clear wins over a simultaneous load
        if (clear) begin
          loaded_count_d = CNT_ZERO;
        end else if (load_valid && load_ready_q) begin
          mem_we_s       = 1'b1;
          loaded_count_d = loaded_count_q + CNT_ONE;
        end else begin
          loaded_count_d = loaded_count_q;
        end

        if (start && !abort && (n_start_s != CNT_ZERO)) begin
          state_d  = PLAY;
          n_d      = n_start_s;
          p_d      = p_start_s;
          pace_d   = P_ZERO;
          rd_ptr_d = CNT_ZERO;
`ifdef SAMPLE_TX_LOOP_EN
          loop_d   = loop_en;
`else
          loop_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      PLAY: begin
        if (abort) begin
          // gating the read here means nothing is left in flight
          state_d = IDLE;
        end else begin
          if (pace_q == P_ZERO) begin
            if (rd_ptr_q < n_q) begin
              rd_fire_s   = 1'b1;
              out_valid_d = 1'b1;
              pace_d      = p_q - P_ONE;
              if (last_rd_s) begin
                done_d   = 1'b1;
                rd_ptr_d = loop_q ? CNT_ZERO : (rd_ptr_q + CNT_ONE);
              end else begin
                rd_ptr_d = rd_ptr_q + CNT_ONE;
              end
            end else begin
              pace_d = pace_q;
            end
          end else begin
            pace_d = pace_q - P_ONE;
          end

          // leave on the cycle the final sample is presented
          if (done_q && !loop_q) begin
            state_d = IDLE;
          end else begin
            state_d = PLAY;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    load_ready_d = (state_d == IDLE) && (loaded_count_d < DEPTH_C);
    busy_d       = (state_d == PLAY);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      loaded_count_q <= CNT_ZERO;
      n_q            <= CNT_ZERO;
      p_q            <= P_ONE;
      pace_q         <= P_ZERO;
      rd_ptr_q       <= CNT_ZERO;
      loop_q         <= 1'b0;
      load_ready_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      loaded_count_q <= loaded_count_d;
      n_q            <= n_d;
      p_q            <= p_d;
      pace_q         <= pace_d;
      rd_ptr_q       <= rd_ptr_d;
      loop_q         <= loop_d;
      load_ready_q   <= load_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      out_valid_q    <= out_valid_d;
    end
  end

  sample_tx_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_we_s),
    .wr_addr (loaded_count_q[ADDR_W-1:0]),
    .wr_data (load_sample),
    .rd_en   (rd_fire_s),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (rd_data_s)
  );

  assign load_ready   = load_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign out_valid    = out_valid_q;
  assign out_sample   = rd_data_s;
  assign loaded_count = loaded_count_q;

endmodule

// File: tb/tb_sample_stream_tx.sv
// Scoreboard bench for sample_stream_tx: each start pushes the expected
// (cycle, sample, done) triples; a negedge monitor pops and compares them
// whenever out_valid is high.
module tb_sample_stream_tx;

  localparam int DW    = 16;
  localparam int DEPTH = 256;
  localparam int PW    = 16;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [DW-1:0] load_sample;
  logic          load_ready;
  logic          clear;
  logic          start;
  logic [AW:0]   num_samples;
  logic [PW-1:0] period;
  logic          abort;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic [DW-1:0] out_sample;
  logic [AW:0]   loaded_count;
`ifdef SAMPLE_TX_LOOP_EN
  logic          loop_en;
`endif

  always #5 clk = ~clk;

  sample_stream_tx dut (
    .clk          (clk),
    .rst          (rst),
`ifdef SAMPLE_TX_LOOP_EN
    .loop_en      (loop_en),
`endif
    .load_valid   (load_valid),
    .load_sample  (load_sample),
    .load_ready   (load_ready),
    .clear        (clear),
    .start        (start),
    .num_samples  (num_samples),
    .period       (period),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .out_valid    (out_valid),
    .out_sample   (out_sample),
    .loaded_count (loaded_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] s;
    logic          d;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] model_mem [DEPTH];
  int            model_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every out_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got sample %0d at cycle %0d, expected no output",
                 $signed(out_sample), cyc);
      end else begin
        e = exp_q.pop_front();
        chk("out_cycle", cyc, e.cyc);
        chk("out_sample", {16'h0000, out_sample}, {16'h0000, e.s});
        chk("done_with_out", {31'd0, done}, {31'd0, e.d});
      end
    end else if (done !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL done_without_out_valid: got done=%b at cycle %0d, expected 0", done, cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic load(input logic [DW-1:0] v);
    load_valid  = 1'b1;
    load_sample = v;
    if (model_cnt < DEPTH) begin
      model_mem[model_cnt] = v;
      model_cnt++;
    end
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear     = 1'b0;
    model_cnt = 0;
  endtask

  // lim < 0: expect one full pass; otherwise expect exactly lim outputs.
  task automatic do_start(input int n, input int p, input logic lp, input int lim, output int t);
    int   ne;
    int   pe;
    int   nout;
    exp_t e;
    ne = (n < model_cnt) ? n : model_cnt;
    pe = (p == 0) ? 1 : p;
    nout = (lim < 0) ? ne : lim;
    num_samples = (AW + 1)'(n);
    period      = PW'(p);
    start       = 1'b1;
`ifdef SAMPLE_TX_LOOP_EN
    loop_en     = lp;
`endif
    t = cyc;
    if (ne > 0) begin
      for (int k = 0; k < nout; k++) begin
        e.cyc = t + 2 + k * pe;
        e.s   = model_mem[k % ne];
        e.d   = ((k % ne) == ne - 1);
        exp_q.push_back(e);
      end
    end
    tick();
    start = 1'b0;
`ifdef SAMPLE_TX_LOOP_EN
    loop_en = 1'b0;
`endif
  endtask

  task automatic drain(input int c);
    wait_until(c);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst         = 1'b1;
    load_valid  = 1'b0;
    load_sample = '0;
    clear       = 1'b0;
    start       = 1'b0;
    num_samples = '0;
    period      = '0;
    abort       = 1'b0;
`ifdef SAMPLE_TX_LOOP_EN
    loop_en     = 1'b0;
`endif

    // Reset state
    tick(); tick(); tick();
    chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sample", {16'h0000, out_sample}, 32'd0);
    chk("rst_loaded_count", {23'd0, loaded_count}, 32'd0);
    rst = 1'b0;
    tick(); tick();
    chk("post_rst_load_ready", {31'd0, load_ready}, 32'd1);

    // 8 samples, P=1: back-to-back output, done on the last
    for (int i = -3; i <= 4; i++) load(DW'(i));
    chk("loaded_8", {23'd0, loaded_count}, 32'd8);
    do_start(8, 1, 1'b0, -1, t);
    wait_until(t + 5);
    chk("play_load_ready", {31'd0, load_ready}, 32'd0);
    wait_until(t + 9);
    chk("busy_last", {31'd0, busy}, 32'd1);
    wait_until(t + 10);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("ready_after", {31'd0, load_ready}, 32'd1);
    drain(t + 12);

    // 4 samples at P=5, then period=0 acting as P=1
    do_clear();
    load(16'h8000); load(16'h7FFF); load(16'h0001); load(16'hFFFF);
    chk("loaded_4", {23'd0, loaded_count}, 32'd4);
    do_start(4, 5, 1'b0, -1, t);
    drain(t + 20);
    do_start(4, 0, 1'b0, -1, t);
    drain(t + 8);

    // num_samples beyond loaded_count, then empty record
    do_clear();
    load(16'd7); load(16'd8); load(16'd9);
    do_start(10, 1, 1'b0, -1, t);
    drain(t + 8);
    do_clear();
    do_start(5, 1, 1'b0, -1, t);
    chk("empty_start_busy1", {31'd0, busy}, 32'd0);
    wait_until(t + 3);
    chk("empty_start_busy3", {31'd0, busy}, 32'd0);
    drain(t + 6);

    // Fill to DEPTH; extra load ignored
    for (int i = 0; i < DEPTH; i++) load(DW'(i * 3 - 100));
    chk("full_count", {23'd0, loaded_count}, 32'd256);
    chk("full_ready", {31'd0, load_ready}, 32'd0);
    load(16'd12345);
    chk("full_extra_count", {23'd0, loaded_count}, 32'd256);
    do_start(256, 1, 1'b0, -1, t);
    drain(t + 262);
    do_clear();
    chk("clear_count", {23'd0, loaded_count}, 32'd0);
    chk("clear_ready", {31'd0, load_ready}, 32'd1);

    // Abort after two samples, then replay from sample 0
    for (int i = 0; i < 6; i++) load(DW'(100 + i));
    do_start(6, 3, 1'b0, 2, t);
    wait_until(t + 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    drain(t + 25);
    do_start(6, 3, 1'b0, -1, t);
    drain(t + 22);

    // Reset mid-playback
    do_start(6, 3, 1'b0, 2, t);
    wait_until(t + 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_cnt = 0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_count", {23'd0, loaded_count}, 32'd0);
    chk("rst_mid_ready", {31'd0, load_ready}, 32'd0);
    tick();
    chk("rst_mid_ready_later", {31'd0, load_ready}, 32'd1);
    drain(t + 25);
    for (int i = 0; i < 6; i++) load(DW'(200 + i));
    do_start(6, 3, 1'b0, -1, t);
    drain(t + 22);

`ifdef SAMPLE_TX_LOOP_EN
    // Looping playback: three samples at P=2, stopped by abort
    do_clear();
    load(16'hFFFB); load(16'd6); load(16'd7);
    do_start(3, 2, 1'b1, 7, t);
    wait_until(t + 14);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("loop_abort_busy", {31'd0, busy}, 32'd0);
    drain(t + 30);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sample_stream_tx.md
Name: sample_stream_tx

Overview:
Stimulus transmitter that drives the `in_valid`/`in_sample` input of the EEG processing pipeline (window generator → dual-branch conv → attention → fusion).
- Host logic loads a sample record into an internal sample memory.
- On `start`, the block plays the record out as a paced valid-only stream, one sample every `period` cycles.
- It lets resource-eval and hardware bring-up runs feed the pipeline deterministically, without an external sample source.

Parameters:
DATA_WIDTH, 16, sample width (signed)
DEPTH, 256, sample memory depth in samples (power of two, ≥2)
PERIOD_WIDTH, 16, width of the pacing-period input
ADDR_W, $clog2(DEPTH), derived localparam (not overridable)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
load_valid  in  1  write load_sample at the load pointer when load_ready=1
load_sample  in  DATA_WIDTH  signed sample to store
load_ready  out  1  high when state=IDLE and loaded_count<DEPTH
clear  in  1  IDLE only: loaded_count←0 (memory contents untouched)
start  in  1  begin playback (honoured in IDLE only)
num_samples  in  ADDR_W+1  samples to play; latched on accepted start
period  in  PERIOD_WIDTH  cycles between samples; latched on start; 0 treated as 1
abort  in  1  terminate playback
busy  out  1  high while state=PLAY
done  out  1  one-cycle pulse coincident with the last out_valid of a pass
out_valid  out  1  sample strobe (to pipeline in_valid)
out_sample  out  DATA_WIDTH  signed sample (to pipeline in_sample)
loaded_count  out  ADDR_W+1  number of samples currently loaded

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: load_ready=0 (becomes 1 the cycle after rst deasserts), busy=0, done=0, out_valid=0, out_sample=0, loaded_count=0, state=IDLE. Memory is not cleared.
- Reset mid-playback: output stops at the next edge; no done pulse.
- States: IDLE, PLAY.
- Loading (IDLE only):
  - load_valid&&load_ready → mem[loaded_count]←load_sample; loaded_count++.
  - load_valid while load_ready=0 is ignored.
  - clear takes priority over load in the same cycle.
- Accepting start (IDLE, start=1, abort=0):
  - N = min(num_samples, loaded_count); P = max(period, 1).
  - If N=0, start is ignored: stay IDLE, no done.
  - Otherwise latch N and P, rd_ptr←0, pace counter←0, go to PLAY.
  - start and load in the same cycle: N uses the pre-write loaded_count.
- PLAY:
  - When pace counter=0, issue a synchronous memory read of mem[rd_ptr], then rd_ptr++ and reload counter←P−1; otherwise decrement the counter.
  - Read data appears next cycle with out_valid=1.
  - Start accepted at cycle T → sample k emitted at cycle T+2+k·P.
  - out_valid never high on two consecutive cycles when P>1; P=1 gives back-to-back samples.
  - After the N-th read issues, no further reads.
  - The cycle of the N-th out_valid: done=1; state→IDLE at that edge, so busy=0 from the next cycle.
  - start during PLAY is ignored. load_ready=0 throughout PLAY.
- Abort:
  - abort in PLAY → IDLE at the next edge; out_valid=0 from the next cycle, and any in-flight read result is discarded; no done.
  - abort in IDLE cancels a simultaneous start.
- out_sample holds its last value when out_valid=0.
- Arithmetic: no sample arithmetic; samples pass through bit-exact. rd_ptr is ADDR_W+1 bits; comparison is against the latched N.

Optional Feature:
Macro SAMPLE_TX_LOOP_EN.
- Defined:
  - Adds input `loop_en` (1 bit, latched on start).
  - When latched loop_en=1, after the N-th read rd_ptr wraps to 0 and playback continues with unchanged P spacing, including across the wrap.
  - done pulses with the last sample of every pass.
  - PLAY exits only on abort or rst.
- Undefined: the port is absent and playback is always single-pass.

Decomposition:
- Package `sample_tx_pkg`:
  - state enum tx_state_e {IDLE, PLAY};
  - default DEPTH/PERIOD_WIDTH constants;
  - an addr-width helper function.
- One sub-module, `sample_tx_mem`: simple dual-port RAM, one write port, registered read port, written for BRAM inference.
- Pacing counter, FSM, and output register stay in the top.

Test Plan:
- Load 8 samples (−3,−2,−1,0,1,2,3,4), start N=8 P=1 at cycle T → out_valid high T+2..T+9 with those values in order; done only at T+9; busy low from T+10.
- Load 4 samples, start N=4 P=5 → out_valid at T+2, T+7, T+12, T+17 only; period=0 behaves identically to P=1.
- Load 3, start N=10 → exactly 3 samples emitted, done on the 3rd; loaded_count=0 with start → no output, no done, busy stays 0.
- Fill to DEPTH=256 → load_ready=0, 257th load ignored, loaded_count=256. clear → loaded_count=0 and load_ready=1.
- Start N=6 P=3, abort at T+6 (after 2 samples) → no out_valid from T+7, no done, state IDLE; a new start replays from sample 0. Repeat with rst at T+6 → same.
- [SAMPLE_TX_LOOP_EN] N=3 P=2 loop_en=1 → sequence s0,s1,s2,s0,s1… spaced 2 cycles apart; done on each s2; abort stops it.
